// File: rtl/ddrphy_dqsw_lane_train.sv
// DQSW write-leveling training engine.
// Lanes are trained one at a time, in ascending order. For each lane the engine loads the delay
// line to tap 0, then repeats clear / settle / sample / evaluate / step, and records the tap of
// the first early-to-late transition of the IOD eye-monitor flags.
//
// Ports
//   FAB_CLK, ARST_N           clock and asynchronous active-low reset
//   START, LANE_MASK          training request and the lanes to train (latched on accept)
//   BUSY, DONE                training status
//   LANE_ERR, TAP_VAL         per-lane failure flag and result tap (lane i at [i*TAP_W +: TAP_W])
//   DELAY_LINE_*              IOD delay-line controls and its out-of-range flag
//   EYE_MONITOR_*             IOD eye-monitor flag clear and EARLY/LATE flags
module ddrphy_dqsw_lane_train #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAPS   = 255,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned SAMPLE_CYC = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       START,
  input  logic [NUM_LANES-1:0]       LANE_MASK,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NUM_LANES-1:0]       LANE_ERR,
  output logic [NUM_LANES*TAP_W-1:0] TAP_VAL,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE
);

  localparam int unsigned IdxW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [3:0] {
    StIdle, StSel, StLoad, StClear, StSettle, StSample, StEval, StStep, StFail, StNext, StFin,
    StDone
  } state_e;

  state_e                             st_q;
  logic [NUM_LANES-1:0]               rem_q;     // masked lanes not yet trained
  logic [IdxW-1:0]                    cur_q;     // lane under test
  logic [TAP_W-1:0]                   tap_q;
  logic [7:0]                         cnt_q;
  logic                               early_q, late_q, seen_early_q;
  logic                               busy_q, done_q;
  logic [NUM_LANES-1:0]               lane_err_q;
  logic [NUM_LANES-1:0][TAP_W-1:0]    tap_val_q;
  logic [NUM_LANES-1:0]               load_q, move_q, dir_q, clr_q;

  // Lowest remaining masked lane.
  logic            sel_found;
  logic [IdxW-1:0] sel_idx;
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  // Outputs are registered on entry to the state that owns them, so a pulse is visible exactly
  // while the FSM sits in that state.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      st_q         <= StIdle;
      rem_q        <= '0;
      cur_q        <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      early_q      <= 1'b0;
      late_q       <= 1'b0;
      seen_early_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_err_q   <= '0;
      tap_val_q    <= '0;
      load_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      clr_q        <= '0;
    end else begin
      load_q <= '0;
      move_q <= '0;
      clr_q  <= '0;
      case (st_q)
        StIdle, StDone: begin
          if (START) begin
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            lane_err_q <= '0;
            tap_val_q  <= '0;
            rem_q      <= LANE_MASK;
            st_q       <= StSel;
          end
        end
        StSel: begin
          if (sel_found) begin
            cur_q          <= sel_idx;
            load_q[sel_idx] <= 1'b1;
            dir_q[sel_idx]  <= 1'b1;
            tap_q          <= '0;
            seen_early_q   <= 1'b0;
            st_q           <= StLoad;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st_q   <= StFin;
          end
        end
        StLoad: begin
          clr_q[cur_q] <= 1'b1;
          st_q         <= StClear;
        end
        StClear: begin
          cnt_q <= '0;
          st_q  <= StSettle;
        end
        StSettle: begin
          if (cnt_q == 8'(SETTLE_CYC - 1)) begin
            cnt_q   <= '0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            st_q    <= StSample;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StSample: begin
          early_q <= early_q | EYE_MONITOR_EARLY[cur_q];
          late_q  <= late_q | EYE_MONITOR_LATE[cur_q];
          if (cnt_q == 8'(SAMPLE_CYC - 1)) begin
            st_q <= StEval;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StEval: begin
          if (DELAY_LINE_OUT_OF_RANGE[cur_q] || (tap_q == TAP_W'(MAX_TAPS) &&
              !(late_q && !early_q && seen_early_q))) begin
            // Failure: flag the lane and send the delay line back to tap 0.
            lane_err_q[cur_q] <= 1'b1;
            tap_val_q[cur_q]  <= tap_q;
            load_q[cur_q]     <= 1'b1;
            st_q              <= StFail;
          end else if (late_q && !early_q && seen_early_q) begin
            // Edge found: the delay line is left at this tap.
            tap_val_q[cur_q] <= tap_q;
            dir_q[cur_q]     <= 1'b0;
            st_q             <= StNext;
          end else begin
            // Early together with late still counts as early.
            if (early_q) seen_early_q <= 1'b1;
            move_q[cur_q] <= 1'b1;
            st_q          <= StStep;
          end
        end
        StStep: begin
          tap_q        <= tap_q + TAP_W'(1);
          clr_q[cur_q] <= 1'b1;
          st_q         <= StClear;
        end
        StFail: begin
          dir_q[cur_q] <= 1'b0;
          st_q         <= StNext;
        end
        StNext: begin
          rem_q[cur_q] <= 1'b0;
          st_q         <= StSel;
        end
        StFin: begin
          st_q <= StDone;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign LANE_ERR                = lane_err_q;
  assign TAP_VAL                 = tap_val_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;

endmodule

// File: tb/tb_ddrphy_dqsw_lane_train.sv
// Directed bench for ddrphy_dqsw_lane_train with a two-lane behavioural IOD model.
module tb_ddrphy_dqsw_lane_train;

  logic        clk    = 1'b0;
  logic        arst_n = 1'b0;
  logic        start  = 1'b0;
  logic [1:0]  mask   = 2'b00;
  logic        busy, done;
  logic [1:0]  lane_err;
  logic [15:0] tap_val;
  logic [1:0]  dl_load, dl_move, dl_dir, em_clr;
  logic [1:0]  dl_oor, em_early, em_late;

  ddrphy_dqsw_lane_train #(
    .NUM_LANES (2),
    .TAP_W     (8),
    .MAX_TAPS  (255),
    .SETTLE_CYC(8),
    .SAMPLE_CYC(4)
  ) u_dut (
    .FAB_CLK                (clk),
    .ARST_N                 (arst_n),
    .START                  (start),
    .LANE_MASK              (mask),
    .BUSY                   (busy),
    .DONE                   (done),
    .LANE_ERR               (lane_err),
    .TAP_VAL                (tap_val),
    .DELAY_LINE_LOAD        (dl_load),
    .DELAY_LINE_MOVE        (dl_move),
    .DELAY_LINE_DIRECTION   (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor),
    .EYE_MONITOR_CLEAR_FLAGS(em_clr),
    .EYE_MONITOR_EARLY      (em_early),
    .EYE_MONITOR_LATE       (em_late)
  );

  always #5 clk = ~clk;

  // IOD model: flags derive from the model's own tap position.
  logic [7:0] iod_tap [2] = '{8'd0, 8'd0};
  int         edge_tap [2] = '{1000, 1000};
  logic       no_early = 1'b0;
  logic [1:0] oor_en   = 2'b00;
  int         oor_tap  = 1000;

  always_comb begin
    em_early = '0;
    em_late  = '0;
    dl_oor   = '0;
    for (int i = 0; i < 2; i++) begin
      em_early[i] = !no_early && (int'(iod_tap[i]) < edge_tap[i]);
      em_late[i]  = int'(iod_tap[i]) >= edge_tap[i];
      dl_oor[i]   = oor_en[i] && (int'(iod_tap[i]) >= oor_tap);
    end
  end

  int cyc = 0;
  int load_cnt [2] = '{0, 0};
  int move_cnt [2] = '{0, 0};
  int clr_cnt  [2] = '{0, 0};
  int excl_viol = 0;
  int last_l0_cyc = 0;
  int l1_load_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (dl_load[i]) iod_tap[i] <= 8'd0;
      else if (dl_move[i]) iod_tap[i] <= dl_dir[i] ? iod_tap[i] + 8'd1 : iod_tap[i] - 8'd1;
      if (dl_load[i]) load_cnt[i] <= load_cnt[i] + 1;
      if (dl_move[i]) move_cnt[i] <= move_cnt[i] + 1;
      if (em_clr[i])  clr_cnt[i]  <= clr_cnt[i] + 1;
    end
    if ((dl_load[0] | dl_move[0] | em_clr[0] | dl_dir[0]) &&
        (dl_load[1] | dl_move[1] | em_clr[1] | dl_dir[1])) excl_viol <= excl_viol + 1;
    if (dl_load[0] | dl_move[0] | em_clr[0] | dl_dir[0]) last_l0_cyc <= cyc;
    if (dl_load[1]) l1_load_cyc <= cyc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  int m0, m1, ld0, ld1, c0, c1;
  task automatic snap();
    m0 = move_cnt[0]; m1 = move_cnt[1];
    ld0 = load_cnt[0]; ld1 = load_cnt[1];
    c0 = clr_cnt[0];  c1 = clr_cnt[1];
  endtask

  logic [27:0] all_out;
  assign all_out = {busy, done, lane_err, tap_val, dl_load, dl_move, dl_dir, em_clr};

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 32'(all_out), 32'd0);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_no_busy", 32'(busy), 32'd0);

    // Edge at tap 10 on lane 0; a START mid-sweep must be ignored
    edge_tap[0] = 10; edge_tap[1] = 1000;
    snap();
    pulse_start(2'b01);
    check_eq("edge_busy", 32'(busy), 32'd1);
    check_eq("edge_done_low", 32'(done), 32'd0);
    repeat (50) @(negedge clk);
    pulse_start(2'b11);
    wait_done(4000, "edge_done");
    check_eq("edge_tap", 32'(tap_val[7:0]), 32'd10);
    check_eq("edge_moves", 32'(move_cnt[0] - m0), 32'd10);
    check_eq("edge_err", 32'(lane_err), 32'd0);
    check_eq("edge_dir_low", 32'(dl_dir), 32'd0);
    check_eq("edge_busy_low", 32'(busy), 32'd0);
    check_eq("edge_loads0", 32'(load_cnt[0] - ld0), 32'd1);
    check_eq("edge_ign_start", 32'(load_cnt[1] - ld1), 32'd0);
    check_eq("edge_iod_tap", 32'(iod_tap[0]), 32'd10);

    // LATE only: no edge, sweep to MAX_TAPS and fail
    no_early = 1'b1; edge_tap[0] = 0;
    snap();
    pulse_start(2'b01);
    wait_done(5000, "noedge_done");
    check_eq("noedge_err", 32'(lane_err), 32'h1);
    check_eq("noedge_tap", 32'(tap_val[7:0]), 32'd255);
    check_eq("noedge_moves", 32'(move_cnt[0] - m0), 32'd255);
    check_eq("noedge_loads", 32'(load_cnt[0] - ld0), 32'd2);
    check_eq("noedge_iod_home", 32'(iod_tap[0]), 32'd0);

    // Out of range on lane 1 at tap 37
    no_early = 1'b0; edge_tap[0] = 1000; edge_tap[1] = 1000;
    oor_en = 2'b10; oor_tap = 37;
    snap();
    pulse_start(2'b10);
    wait_done(2000, "oor_done");
    check_eq("oor_err", 32'(lane_err), 32'h2);
    check_eq("oor_tap", 32'(tap_val), 32'h2500);
    check_eq("oor_moves1", 32'(move_cnt[1] - m1), 32'd37);
    check_eq("oor_lane0_quiet", 32'((load_cnt[0] - ld0) + (move_cnt[0] - m0) + (clr_cnt[0] - c0)),
             32'd0);

    // Both lanes, edges at 5 and 20
    oor_en = 2'b00; edge_tap[0] = 5; edge_tap[1] = 20;
    snap();
    pulse_start(2'b11);
    wait_done(2000, "multi_done");
    check_eq("multi_tap", 32'(tap_val), 32'h1405);
    check_eq("multi_err", 32'(lane_err), 32'd0);
    check_eq("multi_moves0", 32'(move_cnt[0] - m0), 32'd5);
    check_eq("multi_moves1", 32'(move_cnt[1] - m1), 32'd20);
    check_eq("multi_order", 32'(last_l0_cyc < l1_load_cyc), 32'd1);

    // Async reset mid-SAMPLE on tap 12, then retrain
    edge_tap[0] = 30; edge_tap[1] = 1000;
    pulse_start(2'b01);
    n = 0;
    while (iod_tap[0] != 8'd12 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_tap12", 32'(iod_tap[0]), 32'd12);
    repeat (10) @(negedge clk);
    check_eq("rst_busy_before", 32'(busy), 32'd1);
    #1 arst_n = 1'b0;
    #1 check_eq("rst_async_outputs", 32'(all_out), 32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_stay_idle", 32'({busy, done}), 32'd0);
    edge_tap[0] = 12;
    snap();
    pulse_start(2'b01);
    wait_done(2000, "retrain_done");
    check_eq("retrain_tap", 32'(tap_val[7:0]), 32'd12);
    check_eq("retrain_moves", 32'(move_cnt[0] - m0), 32'd12);

    // Zero mask
    snap();
    pulse_start(2'b00);
    check_eq("zero_busy", 32'({busy, done}), 32'b10);
    @(negedge clk);
    check_eq("zero_done", 32'({busy, done}), 32'b01);
    check_eq("zero_results", 32'({lane_err, tap_val}), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("zero_no_pulses", 32'((load_cnt[0] - ld0) + (load_cnt[1] - ld1) + (move_cnt[0] - m0) +
             (move_cnt[1] - m1) + (clr_cnt[0] - c0) + (clr_cnt[1] - c1)), 32'd0);

    check_eq("lane_exclusive", 32'(excl_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddrphy_dqsw_lane_train.md
Name: ddrphy_dqsw_lane_train

Overview:
- Multi-lane DQSW write-leveling training engine for the DDR3 PHY.
- Drives the IOD dynamic delay-line controls (load/move/direction) and the eye-monitor clear for each lane.
- Sweeps delay taps, classifies each tap from the IOD EYE_MONITOR_EARLY/LATE flags, and records the tap of the first early-to-late transition per lane.
- Sits between the training sequencer and NUM_LANES DQSW IOD instances; lanes are trained sequentially.

Parameters:
- NUM_LANES, 4, number of byte lanes controlled.
- TAP_W, 8, width of the tap counter and each result field.
- MAX_TAPS, 255, last legal tap index; reaching it without an edge is an error.
- SETTLE_CYC, 8, FAB_CLK cycles waited after a flag clear before sampling (range 1..255).
- SAMPLE_CYC, 4, FAB_CLK cycles over which flags are OR-accumulated (range 1..255).

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on this single clock.
- ARST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin training.
- LANE_MASK  in  NUM_LANES  1 = lane is trained; sampled on accepted START.
- BUSY  out  1  training in progress.
- DONE  out  1  high from sweep completion until the next accepted START.
- LANE_ERR  out  NUM_LANES  per-lane failure flag.
- TAP_VAL  out  NUM_LANES*TAP_W  per-lane result; lane i occupies bits [i*TAP_W +: TAP_W].
- DELAY_LINE_LOAD  out  NUM_LANES  1-cycle pulse; resets the lane delay to tap 0.
- DELAY_LINE_MOVE  out  NUM_LANES  1-cycle pulse; steps the lane delay by one tap.
- DELAY_LINE_DIRECTION  out  NUM_LANES  step direction; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD delay-limit flag.
- EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  1-cycle pulse; clears the lane eye-monitor flags.
- EYE_MONITOR_EARLY  in  NUM_LANES  IOD early flag.
- EYE_MONITOR_LATE  in  NUM_LANES  IOD late flag.

Behaviour:
- Reset:
  - ARST_N low asynchronously forces all outputs, the FSM, and all counters to 0 and the state to IDLE; this applies mid-sweep too.
  - After release, only a fresh START starts training.
- Output timing: all outputs are registered. In any cycle, only the lane under test may have a nonzero LOAD, MOVE, CLEAR, or DIRECTION.
- START acceptance:
  - START is accepted only in IDLE or DONE.
  - On acceptance: BUSY=1 and DONE=0 on the next cycle; LANE_ERR and TAP_VAL are cleared; LANE_MASK is latched.
  - START while BUSY is ignored.
  - LANE_MASK=0 gives BUSY for 1 cycle, then DONE=1, with all results 0.
- FSM states: IDLE, SEL, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, FAIL, NEXT, FIN.
- SEL: advances lane index L to the next masked lane, starting at 0. If no masked lane remains, go to FIN.
- LOAD:
  - DELAY_LINE_LOAD[L]=1 for 1 cycle.
  - tap=0 and seen_early=0.
  - DIRECTION[L]=1 from here until L is left.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS[L]=1 for 1 cycle.
- SETTLE: waits exactly SETTLE_CYC cycles.
- SAMPLE: for SAMPLE_CYC cycles, e |= EARLY[L] and l |= LATE[L]; both accumulators are cleared on entry.
- EVAL (1 cycle), decided by the first matching rule:
  1. OUT_OF_RANGE[L] → FAIL.
  2. l && !e && seen_early → edge found: TAP_VAL[L]=tap, go to NEXT. The delay line stays at the found tap.
  3. If e, set seen_early=1.
  4. tap==MAX_TAPS → FAIL.
  5. Otherwise → STEP.
- STEP: MOVE[L]=1 for 1 cycle, tap += 1, then → CLEAR.
  - Cycles per non-final tap = 3 + SETTLE_CYC + SAMPLE_CYC.
- FAIL:
  - LANE_ERR[L]=1 and TAP_VAL[L]=tap.
  - Pulse DELAY_LINE_LOAD[L] for 1 cycle so the lane returns to tap 0.
  - Then → NEXT.
- NEXT: DIRECTION[L]=0, L += 1, → SEL.
- FIN: BUSY=0 and DONE=1 on the same cycle, → DONE state (reported as DONE/IDLE-equivalent).
- Mixed flags: e && l together counts as early, so no edge is declared at that tap.
- Tap counter: never wraps. The MAX_TAPS check precedes any increment.
- OUT_OF_RANGE timing: asserted during any state, it is acted on only at EVAL.

Test Plan:
- Edge detection (NUM_LANES=2, mask 2'b01, SETTLE=8, SAMPLE=4): EARLY[0]=1 for taps 0..9, LATE[0]=1 from tap 10 → TAP_VAL[7:0]=10, exactly 10 MOVE pulses, LANE_ERR=0, DONE asserted, DIRECTION[0] falls at NEXT.
- No early edge: LATE only from tap 0 and EARLY never set → no edge declared; sweep to MAX_TAPS=255 → LANE_ERR[0]=1, TAP_VAL=255, LOAD pulse after FAIL, 255 MOVE pulses.
- Out of range: assert OUT_OF_RANGE[1] at tap 37 (mask 2'b10) → LANE_ERR[1]=1, TAP_VAL[15:8]=37; lane 0 never pulsed.
- Multi-lane ordering: mask 2'b11, edges at taps 5 and 20 → lane 0 trained fully before lane 1's first LOAD; TAP_VAL=16'h1405.
- Async reset: drop ARST_N mid-SAMPLE on tap 12 → all outputs 0 within the same cycle; START ignored while BUSY; after reset release, a new START retrains from tap 0.
- Zero mask: START with mask 0 → DONE on the 2nd cycle after START, no LOAD/MOVE/CLEAR pulses.
